// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Boot-time program loader and memory-port owner for the 8-bit
//            HMMM core. A host word stream fills program/data memory while
//            the core is held in reset. The core is then released and runs
//            under a watchdog until the host stops it or the watchdog expires.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            host_*            - load handshake (start/valid/data/last/ready)
//                                and run control (go/stop)
//            core_adr/we/wdata - core memory request, routed only in RUN
//            core_reset        - holds the core in reset outside RUN
//            mem_adr/we/wdata  - the single memory port
//            state             - IDLE=0 LOAD=1 LOADED=2 RUN=3 HALT=4
//            words_loaded      - words accepted in the current/last load
//            timeout           - last RUN was ended by the watchdog
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 15,
    parameter int                WDOG_W     = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic              host_go,
    input  logic              host_stop,
    input  logic [ADDR_W-1:0] core_adr,
    input  logic              core_we,
    input  logic [7:0]        core_wdata,
    output logic              core_reset,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   words_loaded,
    output logic              timeout
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_LOADED = 3'd2;
    localparam logic [2:0] c_RUN    = 3'd3;
    localparam logic [2:0] c_HALT   = 3'd4;

    // A zero limit turns the watchdog off entirely.
    localparam logic c_WDOG_EN = (WDOG_LIMIT != '0);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_words;
    logic              r_timeout;
    logic [WDOG_W-1:0] r_wdog;

    logic w_xfer;
    logic w_ptr_end;
    logic w_wdog_hit;
    logic w_enter_load;
    logic w_enter_run;

    // host_ready is high for the whole of LOAD, so a transfer is just valid.
    assign w_xfer     = (r_state == c_LOAD) && host_valid;
    assign w_ptr_end  = (r_ptr == {ADDR_W{1'b1}});
    assign w_wdog_hit = c_WDOG_EN && (r_wdog == WDOG_LIMIT);

    assign w_enter_load = (r_state != c_LOAD) && (w_next == c_LOAD);
    assign w_enter_run  = (r_state != c_RUN)  && (w_next == c_RUN);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. host_start has priority over host_go wherever
    // both are honoured; host_stop has priority over the watchdog.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (host_start) w_next = c_LOAD;
            end
            c_LOAD: begin
                // The 256th word closes the image even without host_last.
                if (w_xfer && (host_last || w_ptr_end)) w_next = c_LOADED;
            end
            c_LOADED, c_HALT: begin
                if (host_start)   w_next = c_LOAD;
                else if (host_go) w_next = c_RUN;
            end
            c_RUN: begin
                if (host_stop)       w_next = c_HALT;
                else if (w_wdog_hit) w_next = c_HALT;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Ready, core reset and the port mux depend on the
    // state register only; mem_we in LOAD follows host_valid directly so
    // each word is written in the cycle it is offered.
    // ------------------------------------------------------------------
    always_comb begin
        host_ready = 1'b0;
        core_reset = 1'b1;
        mem_adr    = r_ptr;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (r_state)
            c_LOAD: begin
                host_ready = 1'b1;
                mem_we     = host_valid;
                mem_wdata  = host_data;
            end
            c_RUN: begin
                core_reset = 1'b0;
                mem_adr    = core_adr;
                mem_we     = core_we;
                mem_wdata  = {{(DATA_W-8){1'b0}}, core_wdata};
            end
            default: begin
                host_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load pointer, word count, watchdog and timeout flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= '0;
            r_words   <= '0;
            r_timeout <= 1'b0;
            r_wdog    <= '0;
        end else begin
            if (w_enter_load) begin
                r_ptr   <= '0;
                r_words <= '0;
            end else if (w_xfer) begin
                // The pointer wraps to 0 after address 255 by overflow.
                r_ptr   <= r_ptr + 1'b1;
                r_words <= r_words + 1'b1;
            end

            if (w_enter_run) begin
                r_wdog <= '0;
            end else if (r_state == c_RUN) begin
                r_wdog <= r_wdog + 1'b1;
            end

            // The flag describes the most recent run only, so a new load
            // or a new run clears it; it then holds through HALT.
            if (w_enter_load || w_enter_run) begin
                r_timeout <= 1'b0;
            end else if ((r_state == c_RUN) && !host_stop && w_wdog_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign state        = r_state;
    assign words_loaded = r_words;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader. Expected memory writes are
//            queued as stimulus is driven and matched against the memory port
//            as writes appear; state and status outputs are checked against
//            constants. A bench-side memory array holds what was written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int c_ADDR_W = 8;
    localparam int c_DATA_W = 15;

    logic                clk;
    logic                reset;
    logic                host_start;
    logic                host_valid;
    logic [c_DATA_W-1:0] host_data;
    logic                host_last;
    logic                host_ready;
    logic                host_go;
    logic                host_stop;
    logic [c_ADDR_W-1:0] core_adr;
    logic                core_we;
    logic [7:0]          core_wdata;
    logic                core_reset;
    logic [c_ADDR_W-1:0] mem_adr;
    logic                mem_we;
    logic [c_DATA_W-1:0] mem_wdata;
    logic [2:0]          state;
    logic [c_ADDR_W:0]   words_loaded;
    logic                timeout;

    typedef struct packed {
        logic [7:0]  adr;
        logic [14:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [14:0]   mem_model [256];
    int            n_total = 0;
    int            n_bad   = 0;

    prog_loader #(
        .ADDR_W    (8),
        .DATA_W    (15),
        .WDOG_W    (16),
        .WDOG_LIMIT(16'd10)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .host_start  (host_start),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_last   (host_last),
        .host_ready  (host_ready),
        .host_go     (host_go),
        .host_stop   (host_stop),
        .core_adr    (core_adr),
        .core_we     (core_we),
        .core_wdata  (core_wdata),
        .core_reset  (core_reset),
        .mem_adr     (mem_adr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .state       (state),
        .words_loaded(words_loaded),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] adr, input logic [14:0] data);
        wr_t e;
        e.adr  = adr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Offer one word in LOAD and record the write it must produce.
    task automatic load_word(input logic [7:0] adr, input logic [14:0] data, input logic last);
        host_valid = 1'b1;
        host_data  = data;
        host_last  = last;
        push_wr(adr, data);
        step();
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic pulse_start();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
    endtask

    // Count cycles with core_reset low; optionally issue one core write.
    task automatic run_count(output int cnt, input bit core_wr);
        cnt = 0;
        while (core_reset === 1'b0 && cnt < 50) begin
            if (core_wr && cnt == 3) begin
                core_we    = 1'b1;
                core_adr   = 8'h40;
                core_wdata = 8'hA5;
                push_wr(8'h40, 15'h00A5);
                #1;
                chk("run_mem_we", 32'(mem_we), 32'd1);
                chk("run_mem_adr", 32'(mem_adr), 32'h40);
                chk("run_mem_wdata", 32'(mem_wdata), 32'h00A5);
            end else begin
                core_we = 1'b0;
            end
            step();
            cnt++;
        end
        core_we = 1'b0;
    endtask

    // Scoreboard: every memory write must match the oldest expected one.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mem_model[mem_adr] = mem_wdata;
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_adr", 32'(mem_adr), 32'(mon_e.adr));
                chk("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          cnt;
        logic [14:0] d;
        logic [14:0] d255;
        logic [14:0] d0;

        reset      = 1'b1;
        host_start = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        host_last  = 1'b0;
        host_go    = 1'b0;
        host_stop  = 1'b0;
        core_adr   = '0;
        core_we    = 1'b0;
        core_wdata = '0;
        step();
        step();

        // Reset values
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_adr", 32'(mem_adr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        step();

        // Short load of three words ending with host_last
        pulse_start();
        chk("t1_state_load", 32'(state), 32'd1);
        chk("t1_ready_high", 32'(host_ready), 32'd1);
        load_word(8'd0, 15'h1234, 1'b0);
        load_word(8'd1, 15'h0001, 1'b0);
        load_word(8'd2, 15'h7FFF, 1'b1);
        chk("t1_state_loaded", 32'(state), 32'd2);
        chk("t1_ready_low", 32'(host_ready), 32'd0);
        chk("t1_words", 32'(words_loaded), 32'd3);
        chk("t1_mem0", 32'(mem_model[0]), 32'h1234);
        chk("t1_mem1", 32'(mem_model[1]), 32'h0001);
        chk("t1_mem2", 32'(mem_model[2]), 32'h7FFF);

        // Full 256-word load with no host_last, valid held for 260 words
        pulse_start();
        chk("t2_words_clr", 32'(words_loaded), 32'd0);
        host_valid = 1'b1;
        host_last  = 1'b0;
        for (int i = 0; i < 260; i++) begin
            d = 15'(i * 37 + 5);
            host_data = d;
            if (i < 256) push_wr(8'(i), d);
            if (i == 255) chk("t2_ready_255", 32'(host_ready), 32'd1);
            if (i == 256) chk("t2_ready_256", 32'(host_ready), 32'd0);
            step();
        end
        host_valid = 1'b0;
        d0   = 15'(5);
        d255 = 15'(255 * 37 + 5);
        chk("t2_state", 32'(state), 32'd2);
        chk("t2_words", 32'(words_loaded), 32'd256);
        chk("t2_ptr_wrap", 32'(mem_adr), 32'd0);
        chk("t2_mem0", 32'(mem_model[0]), 32'(d0));
        chk("t2_mem255", 32'(mem_model[255]), 32'(d255));

        // Run to watchdog expiry with one core write
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        chk("t3_state_run", 32'(state), 32'd3);
        run_count(cnt, 1'b1);
        chk("t3_run_cycles", 32'(cnt), 32'd11);
        chk("t3_state_halt", 32'(state), 32'd4);
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_core_reset", 32'(core_reset), 32'd1);
        chk("t3_mem40", 32'(mem_model[8'h40]), 32'h00A5);

        // host_stop on the watchdog limit cycle wins over the timeout
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t4_still_run", 32'(state), 32'd3);
        host_stop = 1'b1;
        step();
        host_stop = 1'b0;
        chk("t4_state_halt", 32'(state), 32'd4);
        chk("t4_timeout", 32'(timeout), 32'd0);
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        run_count(cnt, 1'b0);
        chk("t4_rerun_cycles", 32'(cnt), 32'd11);
        chk("t4_rerun_timeout", 32'(timeout), 32'd1);

        // Reset in the middle of a load
        pulse_start();
        for (int i = 0; i < 5; i++) load_word(8'(i), 15'(16'h0100 + i), 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_state", 32'(state), 32'd0);
        chk("t5_words", 32'(words_loaded), 32'd0);
        chk("t5_timeout", 32'(timeout), 32'd0);
        chk("t5_mem0", 32'(mem_model[0]), 32'h0100);
        chk("t5_mem4", 32'(mem_model[4]), 32'h0104);
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        chk("t5_go_ignored", 32'(state), 32'd0);
        chk("t5_core_reset", 32'(core_reset), 32'd1);

        // start and go together in HALT: start wins and clears status
        pulse_start();
        load_word(8'd0, 15'h0ABC, 1'b1);
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        run_count(cnt, 1'b0);
        chk("t6_halt", 32'(state), 32'd4);
        chk("t6_timeout_set", 32'(timeout), 32'd1);
        host_start = 1'b1;
        host_go    = 1'b1;
        step();
        host_start = 1'b0;
        host_go    = 1'b0;
        chk("t6_state_load", 32'(state), 32'd1);
        chk("t6_timeout_clr", 32'(timeout), 32'd0);
        chk("t6_words_clr", 32'(words_loaded), 32'd0);
        chk("t6_ptr_clr", 32'(mem_adr), 32'd0);
        load_word(8'd0, 15'h0321, 1'b1);
        chk("t6_words", 32'(words_loaded), 32'd1);
        chk("t6_mem0", 32'(mem_model[0]), 32'h0321);

        step();
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
